data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the MIPS pipeline's MEM-stage data port. It accepts the core's MemRead/MemWrite requests, inserts a configurable number of wait states, and signals completion. It holds the pipeline back with MemStall until each access completes. It sits between the EX/MEM pipeline register outputs (Address, store data, control) and the word-addressed data array, replacing the zero-latency data memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Legal word index is 0..DEPTH_WORDS-1.
- WAIT_STATES, 2: extra cycles between acceptance and response. Range 0..15.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  read request from the MEM stage.
- MemWrite  in  1  write request from the MEM stage.
- Address  in  32  byte address; word index is Address[31:2].
- WriteData  in  32  store data.
- ByteEn  in  4  write byte lanes; bit i enables WriteData[8i+7:8i].
- ReadData  out  32  load data; valid only while ReadValid=1, otherwise 0.
- ReadValid  out  1  one-cycle pulse marking load completion.
- WriteDone  out  1  one-cycle pulse marking store completion.
- MemStall  out  1  pipeline hold; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- AddrError  out  1  one-cycle pulse on a misaligned, out-of-range or conflicting request.

## Operation
- A request is `req = MemRead | MemWrite`. The requester holds Address, WriteData, ByteEn and the request bits stable while MemStall=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE with req and a legal request: latch Address, WriteData, ByteEn and the read/write flag. Load the counter with WAIT_STATES. Go to WAIT, or directly to RESP when WAIT_STATES=0.
- WAIT: decrement the counter each cycle. At 0, go to RESP.
- RESP: lasts one cycle, then returns to IDLE. RESP does not accept a request.
- Write commit: the array is written on the edge that enters RESP, for the enabled byte lanes only. WriteDone=1 in RESP.
- Read: array data for the latched index is registered on the edge that enters RESP. ReadValid=1 and ReadData are driven in RESP.
- Illegal requests are detected in IDLE. Each one pulses AddrError for that cycle, performs no array access, does not assert MemStall, and stays in IDLE:
  - MemRead and MemWrite both high.
  - Address[1:0] != 0.
  - Address[31:2] >= DEPTH_WORDS.
- MemStall = (IDLE and legal req) | WAIT. It is 0 in RESP, so the pipeline advances on the edge that leaves RESP.
- Array contents are not cleared by Reset.

## Timing
- Reset values: state=IDLE, counter=0, ReadData=0, ReadValid=0, WriteDone=0, AddrError=0. MemStall is 0 because state is IDLE and req is ignored while Reset is high.
- Reset asserted mid-access (WAIT) aborts the access. A write not yet committed is dropped. No ReadValid or WriteDone follows.
- Latency: a legal request first seen in cycle N gives a response (RESP) in cycle N+WAIT_STATES+1. MemStall is high for cycles N..N+WAIT_STATES.
- Back-to-back accesses: the earliest next acceptance is the cycle after RESP. Throughput is one access per WAIT_STATES+2 cycles.
- With ByteEn=0 on a write, the write completes normally but no bytes change.
- The counter is 4 bits. WAIT_STATES>15 is a parameter error, caught by an elaboration-time check.

## Structure
- Shared package mips_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - MEM_DEPTH_DEFAULT=1024 and WAIT_DEFAULT=2;
  - a word-index function (Address[31:2]).
- One sub-module, dmem_array_1rw: a DEPTH_WORDS x 32 synchronous single-port array with a 4-bit byte-enable write and a registered read. The FSM, counter and error checks stay in data_mem_responder.

## Test plan
- Run all scenarios at WAIT_STATES=2 unless stated otherwise.
- Write then read: MemWrite, Address=0x10, WriteData=0xDEADBEEF, ByteEn=4'hF, then a read of 0x10.
  - Expect MemStall high 3 cycles and WriteDone in cycle 3.
  - The read returns ReadValid with ReadData=0xDEADBEEF 3 cycles after acceptance.
- Byte lanes: after the previous test, write 0x000000AA with ByteEn=4'b0001 to 0x10. A read of 0x10 returns 0xDEADBEAA.
- Illegal requests: Address=0x13 read, Address=DEPTH_WORDS*4 read, and MemRead=MemWrite=1.
  - Each gives a one-cycle AddrError, MemStall=0, no ReadValid, and no array change.
- Reset mid-access: a write of 0x12345678 to 0x20, with Reset pulsed in the first WAIT cycle.
  - Outputs go to their reset values immediately, with no WriteDone.
  - A later read of 0x20 returns the old contents.
- WAIT_STATES=0: a read is accepted in cycle N, MemStall=1 in cycle N only, and ReadValid in cycle N+1.
- Back-to-back: two reads presented continuously.
  - The second is accepted the cycle after the first RESP.
  - ReadValid pulses are exactly 4 cycles apart.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memState_t;

    localparam int MEM_DEPTH_DEFAULT = 1024;
    localparam int WAIT_DEFAULT      = 2;

    function automatic logic [29:0] wordIndex(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data port: the core (master) issues requests, the responder (slave) completes them.
interface data_mem_responder_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        WriteDone;
    logic        MemStall;
    logic        AddrError;

    modport master (
        output MemRead, MemWrite, Address, WriteData, ByteEn,
        input  ReadData, ReadValid, WriteDone, MemStall, AddrError
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData, ByteEn,
        output ReadData, ReadValid, WriteDone, MemStall, AddrError
    );

endinterface

// File: rtl/dmem_array_1rw.sv
// Word-organised single-port data array: byte-lane write, registered read, contents never reset.
module dmem_array_1rw #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             Clk,
    input  logic             En,
    input  logic             We,
    input  logic [3:0]       ByteEn,
    input  logic [IDX_W-1:0] Index,
    input  logic [31:0]      WData,
    output logic [31:0]      RData
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (En) begin
            if (We) begin
                for (int i = 0; i < 4; i++) begin
                    if (ByteEn[i]) begin
                        mem[Index][8*i +: 8] <= WData[8*i +: 8];
                    end
                end
            end else begin
                RData <= mem[Index];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for the MIPS MEM stage; holds the pipeline until each access completes.
// state | meaning:  IDLE | accept or reject a request,  WAIT | wait-state countdown,  RESP | one-cycle completion
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = MEM_DEPTH_DEFAULT,
    parameter int WAIT_STATES = WAIT_DEFAULT
) (
    input logic                 Clk,
    input logic                 Reset,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : gWaitStatesRange
        $error("data_mem_responder: WAIT_STATES=%0d outside 0..15", WAIT_STATES);
    end

    memState_t        state;
    logic [3:0]       waitCnt;
    logic [3:0]       cntDec;
    logic [IDX_W-1:0] latIdx;
    logic [31:0]      latData;
    logic [3:0]       latBe;
    logic             latWrite;
    logic [IDX_W-1:0] arrIdx;
    logic [31:0]      arrData;
    logic [3:0]       arrBe;
    logic             arrWe;
    logic [31:0]      arrRData;
    logic             readValidQ;
    logic             writeDoneQ;
    logic             req;
    logic             legal;
    logic             accept;
    logic             goResp;
    logic [29:0]      reqWord;

    assign req     = bus.MemRead | bus.MemWrite;
    assign reqWord = wordIndex(bus.Address);
    assign legal   = !(bus.MemRead && bus.MemWrite)
                   && (bus.Address[1:0] == 2'b00)
                   && ({2'b00, reqWord} < 32'(DEPTH_WORDS));
    assign accept  = !Reset && (state == IDLE) && req && legal;
    assign cntDec  = waitCnt - 4'd1;
    assign goResp  = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cntDec == 4'd0));

    // Zero-wait accesses reach the array on the accepting edge, before the request is latched.
    always_comb begin
        arrIdx  = latIdx;
        arrData = latData;
        arrBe   = latBe;
        arrWe   = latWrite;
        if (state == IDLE) begin
            arrIdx  = reqWord[IDX_W-1:0];
            arrData = bus.WriteData;
            arrBe   = bus.ByteEn;
            arrWe   = bus.MemWrite;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            latIdx     <= '0;
            latData    <= 32'd0;
            latBe      <= 4'd0;
            latWrite   <= 1'b0;
            readValidQ <= 1'b0;
            writeDoneQ <= 1'b0;
        end else begin
            readValidQ <= goResp && !arrWe;
            writeDoneQ <= goResp && arrWe;
            case (state)
                IDLE: begin
                    if (accept) begin
                        latIdx   <= reqWord[IDX_W-1:0];
                        latData  <= bus.WriteData;
                        latBe    <= bus.ByteEn;
                        latWrite <= bus.MemWrite;
                        waitCnt  <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= cntDec;
                    if (cntDec == 4'd0) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) uArray (
        .Clk    (Clk),
        .En     (goResp),
        .We     (arrWe),
        .ByteEn (arrBe),
        .Index  (arrIdx),
        .WData  (arrData),
        .RData  (arrRData)
    );

    assign bus.MemStall  = accept || (state == WAIT);
    assign bus.AddrError = !Reset && (state == IDLE) && req && !legal;
    assign bus.ReadValid = readValidQ;
    assign bus.WriteDone = writeDoneQ;
    assign bus.ReadData  = readValidQ ? arrRData : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked every cycle against a timeline model.
module tb_data_mem_responder;

    localparam int W0   = 2;
    localparam int D0   = 1024;
    localparam int W1   = 0;
    localparam int D1   = 64;
    localparam int POOL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH_WORDS(D0), .WAIT_STATES(W0)) dut0 (.Clk(clk), .Reset(rst), .bus(bus0));
    data_mem_responder #(.DEPTH_WORDS(D1), .WAIT_STATES(W1)) dut1 (.Clk(clk), .Reset(rst), .bus(bus1));

    logic        mr [2];
    logic        mw [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic [31:0] rd [2];
    logic        rv [2];
    logic        wdn[2];
    logic        st [2];
    logic        ae [2];

    assign bus0.MemRead   = mr[0];
    assign bus0.MemWrite  = mw[0];
    assign bus0.Address   = ad[0];
    assign bus0.WriteData = wd[0];
    assign bus0.ByteEn    = be[0];
    assign bus1.MemRead   = mr[1];
    assign bus1.MemWrite  = mw[1];
    assign bus1.Address   = ad[1];
    assign bus1.WriteData = wd[1];
    assign bus1.ByteEn    = be[1];

    assign rd[0]  = bus0.ReadData;
    assign rv[0]  = bus0.ReadValid;
    assign wdn[0] = bus0.WriteDone;
    assign st[0]  = bus0.MemStall;
    assign ae[0]  = bus0.AddrError;
    assign rd[1]  = bus1.ReadData;
    assign rv[1]  = bus1.ReadValid;
    assign wdn[1] = bus1.WriteDone;
    assign st[1]  = bus1.MemStall;
    assign ae[1]  = bus1.AddrError;

    function automatic int waitOf(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic int depthOf(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic logic legalReq(input int k, input logic r, input logic w, input logic [31:0] a);
        return !(r && w) && (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(depthOf(k)));
    endfunction

    task automatic check1(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
        end
    endtask

    // Transaction timeline model: an accepted access owns the port until cycle accept+W+1.
    logic [31:0] mdl   [2][POOL];
    bit          mBusy [2] = '{0, 0};
    int          mResp [2];
    bit          mWr   [2];
    int          mIdx  [2];
    logic [31:0] mData [2];
    logic [3:0]  mBe   [2];

    task automatic modelStep(input int k);
        logic        eSt;
        logic        eAe;
        logic        eRv;
        logic        eWd;
        logic [31:0] eRd;
        eSt = 0; eAe = 0; eRv = 0; eWd = 0; eRd = 32'd0;
        if (rst) begin
            mBusy[k] = 0;
        end else if (mBusy[k] && cyc == mResp[k]) begin
            mBusy[k] = 0;
            if (mWr[k]) begin
                eWd = 1;
                for (int i = 0; i < 4; i++)
                    if (mBe[k][i]) mdl[k][mIdx[k]][8*i +: 8] = mData[k][8*i +: 8];
            end else begin
                eRv = 1;
                eRd = mdl[k][mIdx[k]];
            end
        end else if (mBusy[k]) begin
            eSt = 1;
        end else if (mr[k] || mw[k]) begin
            if (legalReq(k, mr[k], mw[k], ad[k])) begin
                eSt      = 1;
                mBusy[k] = 1;
                mResp[k] = cyc + waitOf(k) + 1;
                mWr[k]   = mw[k];
                mIdx[k]  = int'(ad[k][31:2]);
                mData[k] = wd[k];
                mBe[k]   = be[k];
            end else begin
                eAe = 1;
            end
        end
        check1("MemStall",  k, {31'd0, st[k]},  {31'd0, eSt});
        check1("AddrError", k, {31'd0, ae[k]},  {31'd0, eAe});
        check1("ReadValid", k, {31'd0, rv[k]},  {31'd0, eRv});
        check1("WriteDone", k, {31'd0, wdn[k]}, {31'd0, eWd});
        check1("ReadData",  k, rd[k], eRd);
    endtask

    always @(negedge clk) begin
        modelStep(0);
        modelStep(1);
    end

    // Present one request for as long as the protocol holds it, recording what the DUT did relative to cycle 0.
    task automatic doReq(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         output int stalls, output int respAt, output int errs,
                         output logic [31:0] data, output int startCyc);
        int hold;
        stalls = 0; respAt = -1; errs = 0; data = 32'd0; startCyc = cyc;
        mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d; be[k] = b;
        hold = legalReq(k, r, w, a) ? waitOf(k) + 2 : 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (st[k]) stalls++;
            if (ae[k]) errs++;
            if ((rv[k] || wdn[k]) && respAt < 0) begin
                respAt = i;
                data   = rd[k];
            end
            @(posedge clk); #1;
        end
        mr[k] = 0; mw[k] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int          s, r, e, t, s2, r2, e2, t2;
    logic [31:0] dv, dv2;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mr[k] = 0; mw[k] = 0; ad[k] = 32'd0; wd[k] = 32'd0; be[k] = 4'd0;
        end
        mr[0] = 1;                                  // a request during reset must be ignored
        repeat (3) @(posedge clk);
        #1;
        check1("reset_stall",     0, {31'd0, st[0]},  32'd0);
        check1("reset_readvalid", 0, {31'd0, rv[0]},  32'd0);
        check1("reset_writedone", 0, {31'd0, wdn[0]}, 32'd0);
        check1("reset_addrerror", 0, {31'd0, ae[0]},  32'd0);
        check1("reset_readdata",  0, rd[0], 32'd0);
        mr[0] = 0;
        rst   = 0;
        idle(2);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < POOL; i++)
                doReq(k, 0, 1, 32'(i * 4), $urandom, 4'hF, s, r, e, dv, t);

        doReq(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, s, r, e, dv, t);
        check1("wr_stall_cycles", 0, s, 32'd3);
        check1("wr_done_cycle",   0, r, 32'd3);
        doReq(0, 1, 0, 32'h10, 32'd0, 4'h0, s, r, e, dv, t);
        check1("rd_valid_cycle", 0, r, 32'd3);
        check1("rd_data",        0, dv, 32'hDEADBEEF);

        doReq(0, 0, 1, 32'h10, 32'h000000AA, 4'b0001, s, r, e, dv, t);
        doReq(0, 1, 0, 32'h10, 32'd0, 4'h0, s, r, e, dv, t);
        check1("byte_lane_data", 0, dv, 32'hDEADBEAA);

        doReq(0, 1, 0, 32'h13, 32'd0, 4'h0, s, r, e, dv, t);
        check1("misaligned_err",   0, e, 32'd1);
        check1("misaligned_stall", 0, s, 32'd0);
        check1("misaligned_resp",  0, r, 32'hFFFFFFFF);
        doReq(0, 1, 0, 32'(D0 * 4), 32'd0, 4'h0, s, r, e, dv, t);
        check1("range_err",   0, e, 32'd1);
        check1("range_stall", 0, s, 32'd0);
        check1("range_resp",  0, r, 32'hFFFFFFFF);
        doReq(0, 1, 1, 32'h10, 32'h0, 4'hF, s, r, e, dv, t);
        check1("both_err",   0, e, 32'd1);
        check1("both_stall", 0, s, 32'd0);
        check1("both_resp",  0, r, 32'hFFFFFFFF);
        doReq(0, 1, 0, 32'h10, 32'd0, 4'h0, s, r, e, dv, t);
        check1("illegal_no_change", 0, dv, 32'hDEADBEAA);

        doReq(0, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, s, r, e, dv, t);
        mw[0] = 1; ad[0] = 32'h20; wd[0] = 32'h12345678; be[0] = 4'hF;
        @(negedge clk);
        check1("abort_accept_stall", 0, {31'd0, st[0]}, 32'd1);
        @(posedge clk); #1;
        rst   = 1;
        mw[0] = 0;
        #1;
        check1("abort_stall",     0, {31'd0, st[0]},  32'd0);
        check1("abort_writedone", 0, {31'd0, wdn[0]}, 32'd0);
        check1("abort_readvalid", 0, {31'd0, rv[0]},  32'd0);
        @(posedge clk); #1;
        rst = 0;
        idle(4);
        doReq(0, 1, 0, 32'h20, 32'd0, 4'h0, s, r, e, dv, t);
        check1("abort_old_contents", 0, dv, 32'hCAFEF00D);

        doReq(1, 0, 1, 32'h8, 32'h0BADCAFE, 4'hF, s, r, e, dv, t);
        doReq(1, 1, 0, 32'h8, 32'd0, 4'h0, s, r, e, dv, t);
        check1("w0_stall_cycles", 1, s, 32'd1);
        check1("w0_valid_cycle",  1, r, 32'd1);
        check1("w0_data",         1, dv, 32'h0BADCAFE);

        doReq(0, 1, 0, 32'h10, 32'd0, 4'h0, s, r, e, dv, t);
        doReq(0, 1, 0, 32'h20, 32'd0, 4'h0, s2, r2, e2, dv2, t2);
        check1("b2b_second_accept", 0, r2, 32'd3);
        check1("b2b_spacing",       0, 32'((t2 + r2) - (t + r)), 32'd4);
        check1("b2b_data",          0, dv2, 32'hCAFEF00D);

        repeat (300) begin
            int          k;
            int          kind;
            logic        rr;
            logic        ww;
            logic [31:0] a;
            k    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            rr   = 1'($urandom_range(0, 1));
            ww   = !rr;
            a    = 32'($urandom_range(0, POOL - 1)) << 2;
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            else if (kind == 1) a = 32'(depthOf(k) + int'($urandom_range(0, 100))) << 2;
            else if (kind == 2) begin rr = 1; ww = 1; end
            doReq(k, rr, ww, a, $urandom, 4'($urandom_range(0, 15)), s, r, e, dv, t);
            idle(int'($urandom_range(0, 2)));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
